// File: rtl/discharge_pulse_scheduler.sv
// ---------------------------------------------------------------------------
// discharge_pulse_scheduler
//
// Sequences EDM discharge pulses for the buck current path:
//   IDLE -> OPEN (open-gap voltage, wait for breakdown) -> DISCHARGE (Ton)
//        -> TOFF (cooling) -> OPEN ...
// A short during DISCHARGE diverts through SHORT (fixed back-off) before TOFF.
// Configuration is latched only at pulse boundaries (start from IDLE and the
// end of TOFF), so host register writes never disturb a pulse in flight.
//
// Optional feature macro: OPEN_TIMEOUT_EN
//   defined   : OPEN gives up after OPEN_MAX_US without breakdown and goes to
//               TOFF (or IDLE if a stop is pending).
//   undefined : OPEN waits indefinitely for breakdown or stop.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, stop        one-cycle host requests
//   cfg_waveform/ton/toff/ip   host configuration (sampled at boundaries)
//   breakdown, short_circuit   synchronised gap status
//   open_voltage       apply open-gap voltage (OPEN)
//   waveform_out/ip_out latched waveform code / peak current in DISCHARGE
//   timer_us           microseconds elapsed in the current state
//   busy               state is not IDLE
//   cfg_err            one-cycle pulse when a (re)start is rejected
//   pulse_count        completed discharges (wrapping)
//   short_count        short events (saturating)
// ---------------------------------------------------------------------------
module discharge_pulse_scheduler #(
   parameter int CLK_PER_US       = 100,
   parameter int SHORT_BACKOFF_US = 50,
   parameter int OPEN_MAX_US      = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] cfg_waveform,
   input  logic [15:0] cfg_ton,
   input  logic [15:0] cfg_toff,
   input  logic [15:0] cfg_ip,
   input  logic        breakdown,
   input  logic        short_circuit,
   output logic        open_voltage,
   output logic [15:0] waveform_out,
   output logic [15:0] ip_out,
   output logic [15:0] timer_us,
   output logic        busy,
   output logic        cfg_err,
   output logic [31:0] pulse_count,
   output logic [15:0] short_count
);

   localparam int              PW         = $clog2(CLK_PER_US);
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_PER_US - 1);
   // Back-off of 0 us is treated as a single microsecond.
   localparam logic [15:0]     SHORT_LAST = 16'((SHORT_BACKOFF_US > 0) ? SHORT_BACKOFF_US - 1 : 0);
   localparam logic [15:0]     OPEN_LAST  = 16'((OPEN_MAX_US > 0) ? OPEN_MAX_US - 1 : 0);
`ifdef OPEN_TIMEOUT_EN
   localparam bit              TIMEOUT_EN = 1'b1;
`else
   localparam bit              TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_OPEN, S_DISCHARGE, S_TOFF, S_SHORT
   } state_t;

   state_t         state_reg, state_next;
   logic [PW-1:0]  presc_reg;
   logic [15:0]    timer_reg;
   logic [15:0]    wf_l_reg, ton_l_reg, toff_l_reg, ip_l_reg;
   logic           stop_pend_reg, stop_pend_next;
   logic           open_voltage_reg, busy_reg, cfg_err_reg;
   logic [15:0]    waveform_out_reg, ip_out_reg, short_count_reg;
   logic [31:0]    pulse_count_reg;

   logic           tick;
   logic           latch_cfg, err_next, pulse_inc, short_inc;

   function automatic logic cfg_ok(input logic [15:0] wf, input logic [15:0] ton);
      return (ton != 16'd0) && (wf[15] || wf == 16'h0002 || wf == 16'h0004);
   endfunction

   assign tick = (presc_reg == PRESC_LAST);

   always_comb begin
      state_next     = state_reg;
      stop_pend_next = stop_pend_reg;
      latch_cfg      = 1'b0;
      err_next       = 1'b0;
      pulse_inc      = 1'b0;
      short_inc      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok(cfg_waveform, cfg_ton)) begin
                  latch_cfg  = 1'b1;
                  state_next = S_OPEN;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         S_OPEN: begin
            if (stop) begin
               state_next = S_IDLE;
            end else if (breakdown) begin
               state_next = S_DISCHARGE;
            end else if (TIMEOUT_EN && tick && timer_reg == OPEN_LAST) begin
               state_next = stop_pend_reg ? S_IDLE : S_TOFF;
            end
         end
         S_DISCHARGE: begin
            if (stop) stop_pend_next = 1'b1;
            // Short wins over Ton expiry in the same cycle.
            if (short_circuit) begin
               state_next = S_SHORT;
               short_inc  = 1'b1;
            end else if (tick && timer_reg == ton_l_reg - 16'd1) begin
               state_next = S_TOFF;
               pulse_inc  = 1'b1;
            end
         end
         S_TOFF: begin
            if (stop) stop_pend_next = 1'b1;
            if (toff_l_reg == 16'd0 || (tick && timer_reg == toff_l_reg - 16'd1)) begin
               // A stop landing on the very last TOFF cycle is honoured too.
               if (stop_pend_reg || stop) begin
                  state_next = S_IDLE;
               end else if (cfg_ok(cfg_waveform, cfg_ton)) begin
                  latch_cfg  = 1'b1;
                  state_next = S_OPEN;
               end else begin
                  err_next   = 1'b1;
                  state_next = S_IDLE;
               end
            end
         end
         S_SHORT: begin
            if (stop) stop_pend_next = 1'b1;
            if (tick && timer_reg == SHORT_LAST) state_next = S_TOFF;
         end
         default: state_next = S_IDLE;
      endcase
      if (state_next == S_IDLE) stop_pend_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         presc_reg        <= '0;
         timer_reg        <= '0;
         wf_l_reg         <= '0;
         ton_l_reg        <= '0;
         toff_l_reg       <= '0;
         ip_l_reg         <= '0;
         stop_pend_reg    <= 1'b0;
         open_voltage_reg <= 1'b0;
         waveform_out_reg <= '0;
         ip_out_reg       <= '0;
         busy_reg         <= 1'b0;
         cfg_err_reg      <= 1'b0;
         pulse_count_reg  <= '0;
         short_count_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         stop_pend_reg <= stop_pend_next;

         // Every state entry restarts the microsecond time base.
         if (state_next != state_reg) begin
            presc_reg <= '0;
            timer_reg <= '0;
         end else if (tick) begin
            presc_reg <= '0;
            if (timer_reg != 16'hFFFF) timer_reg <= timer_reg + 16'd1;
         end else begin
            presc_reg <= presc_reg + PW'(1);
         end

         if (latch_cfg) begin
            wf_l_reg   <= cfg_waveform;
            ton_l_reg  <= cfg_ton;
            toff_l_reg <= cfg_toff;
            ip_l_reg   <= cfg_ip;
         end

         // Outputs are registered from the next state so they line up with
         // the state register. DISCHARGE is only entered from OPEN, where no
         // latch happens, so the latched values are already stable.
         open_voltage_reg <= (state_next == S_OPEN);
         waveform_out_reg <= (state_next == S_DISCHARGE) ? wf_l_reg : 16'd0;
         ip_out_reg       <= (state_next == S_DISCHARGE) ? ip_l_reg : 16'd0;
         busy_reg         <= (state_next != S_IDLE);
         cfg_err_reg      <= err_next;

         if (pulse_inc) pulse_count_reg <= pulse_count_reg + 32'd1;
         if (short_inc && short_count_reg != 16'hFFFF) short_count_reg <= short_count_reg + 16'd1;
      end
   end

   assign open_voltage = open_voltage_reg;
   assign waveform_out = waveform_out_reg;
   assign ip_out       = ip_out_reg;
   assign timer_us     = timer_reg;
   assign busy         = busy_reg;
   assign cfg_err      = cfg_err_reg;
   assign pulse_count  = pulse_count_reg;
   assign short_count  = short_count_reg;

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// ---------------------------------------------------------------------------
// tb_discharge_pulse_scheduler
//
// Drives directed and randomized pulse scenarios. Expected phase lengths,
// timer values, drives and counters come from arithmetic on the configured
// Ton/Toff/back-off values (a phase-level view of the scheduler), not from a
// cycle-by-cycle copy of the state machine.
// ---------------------------------------------------------------------------
module tb_discharge_pulse_scheduler;

   localparam int CPU = 4;
   localparam int SB  = 3;
   localparam int OMX = 5;

   logic        clk = 1'b0;
   logic        rst, start, stop, breakdown, short_circuit;
   logic [15:0] cfg_waveform, cfg_ton, cfg_toff, cfg_ip;
   logic        open_voltage, busy, cfg_err;
   logic [15:0] waveform_out, ip_out, timer_us, short_count;
   logic [31:0] pulse_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_pulses = 0;
   int exp_shorts = 0;

   discharge_pulse_scheduler #(
      .CLK_PER_US(CPU), .SHORT_BACKOFF_US(SB), .OPEN_MAX_US(OMX)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_waveform(cfg_waveform), .cfg_ton(cfg_ton), .cfg_toff(cfg_toff), .cfg_ip(cfg_ip),
      .breakdown(breakdown), .short_circuit(short_circuit),
      .open_voltage(open_voltage), .waveform_out(waveform_out), .ip_out(ip_out),
      .timer_us(timer_us), .busy(busy), .cfg_err(cfg_err),
      .pulse_count(pulse_count), .short_count(short_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic int off_cycles(input int toff);
      return (toff == 0) ? 1 : toff * CPU;
   endfunction

   function automatic logic [15:0] rand_wf();
      logic [15:0] w;
      case ($urandom_range(0, 2))
         0:       w = 16'h0002;
         1:       w = 16'h0004;
         default: w = 16'h8000 | 16'($urandom_range(0, 32767));
      endcase
      return w;
   endfunction

   task automatic set_cfg(input logic [15:0] wf, input logic [15:0] ton,
                          input logic [15:0] toff, input logic [15:0] ip);
      cfg_waveform = wf; cfg_ton = ton; cfg_toff = toff; cfg_ip = ip;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   // Runs one pulse from OPEN: waits bd_delay cycles, fires breakdown, then
   // measures DISCHARGE and the following off period. Optionally pulses stop
   // / short_circuit at given DISCHARGE cycle indices and presents a new
   // configuration on the first DISCHARGE cycle.
   task automatic run_pulse(input int bd_delay, input int stop_at, input int short_at,
                            input bit chg, input logic [15:0] nwf, input logic [15:0] nton,
                            input logic [15:0] ntoff, input logic [15:0] nip,
                            output int dis_len, output int off_len,
                            output logic [15:0] wf_seen, output logic [15:0] ip_seen,
                            output int tmr_bad, output int drv_bad);
      int  exp_t;
      bit  shorted;
      drv_bad = 0;
      tmr_bad = 0;
      for (int i = 0; i < bd_delay; i++) begin
         if (open_voltage !== 1'b1) drv_bad++;
         cyc();
      end
      breakdown = 1'b1; cyc(); breakdown = 1'b0;
      wf_seen = waveform_out;
      ip_seen = ip_out;
      dis_len = 0;
      while (waveform_out != 16'd0 && dis_len < 5000) begin
         if (timer_us !== 16'(dis_len / CPU)) tmr_bad++;
         if (waveform_out !== wf_seen || ip_out !== ip_seen || open_voltage !== 1'b0) drv_bad++;
         if (dis_len == 0 && chg) set_cfg(nwf, nton, ntoff, nip);
         stop          = (dis_len == stop_at);
         short_circuit = (dis_len == short_at);
         dis_len++;
         cyc();
      end
      stop = 1'b0;
      short_circuit = 1'b0;
      shorted = (short_at >= 0) && (dis_len == short_at + 1);
      off_len = 0;
      while (busy === 1'b1 && open_voltage === 1'b0 && off_len < 5000) begin
         exp_t = (shorted && off_len >= SB * CPU) ? (off_len - SB * CPU) / CPU : off_len / CPU;
         if (timer_us !== 16'(exp_t)) tmr_bad++;
         if (waveform_out !== 16'd0 || ip_out !== 16'd0) drv_bad++;
         off_len++;
         cyc();
      end
      $display("pulse: wf=%04h ip=%04h discharge=%0d off=%0d short=%0b busy_after=%0b pulses=%0d shorts=%0d",
               wf_seen, ip_seen, dis_len, off_len, shorted, busy, pulse_count, short_count);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; stop = 0; breakdown = 0; short_circuit = 0;
      set_cfg(16'h0002, 16'd3, 16'd2, 16'h0100);
      repeat (3) cyc();
      n_cmp++; if (open_voltage !== 1'b0) begin n_bad++; $display("FAIL reset_open: got %0b want 0", open_voltage); end
      n_cmp++; if (waveform_out !== 16'd0 || ip_out !== 16'd0) begin n_bad++; $display("FAIL reset_drive: got wf=%h ip=%h want 0", waveform_out, ip_out); end
      n_cmp++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got busy=%b err=%b want 0", busy, cfg_err); end
      n_cmp++; if (pulse_count !== 32'd0 || short_count !== 16'd0 || timer_us !== 16'd0) begin n_bad++; $display("FAIL reset_counters: got p=%0d s=%0d t=%0d want 0", pulse_count, short_count, timer_us); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      int dl, ol, tb, db;
      logic [15:0] ws, is;
      set_cfg(16'h0002, 16'd3, 16'd2, 16'h0100);
      do_start();
      n_cmp++; if (open_voltage !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_start_latency: got open=%b busy=%b want 1/1", open_voltage, busy); end
      run_pulse(5, -1, -1, 1'b0, 0, 0, 0, 0, dl, ol, ws, is, tb, db);
      exp_pulses++;
      n_cmp++; if (dl !== 12) begin n_bad++; $display("FAIL basic_discharge_len: got %0d want 12", dl); end
      n_cmp++; if (ws !== 16'h0002 || is !== 16'h0100) begin n_bad++; $display("FAIL basic_drive: got wf=%h ip=%h want 0002/0100", ws, is); end
      n_cmp++; if (ol !== 8) begin n_bad++; $display("FAIL basic_toff_len: got %0d want 8", ol); end
      n_cmp++; if (tb !== 0 || db !== 0) begin n_bad++; $display("FAIL basic_timer_drive: got timer_errs=%0d drive_errs=%0d want 0", tb, db); end
      n_cmp++; if (open_voltage !== 1'b1 || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL basic_reopen: got open=%b pulses=%0d want 1/%0d", open_voltage, pulse_count, exp_pulses); end
      stop = 1'b1; cyc(); stop = 1'b0;
      n_cmp++; if (busy !== 1'b0 || open_voltage !== 1'b0) begin n_bad++; $display("FAIL basic_stop_open: got busy=%b open=%b want 0/0", busy, open_voltage); end
   endtask

   task automatic test_cfg_err();
      int dl, ol, tb, db;
      logic [15:0] ws, is, w;
      for (int k = 0; k < 5; k++) begin
         w = 16'($urandom_range(0, 32767));
         if (w == 16'h0002 || w == 16'h0004) w = 16'h0006;
         case (k)
            0:       set_cfg(16'h0006, 16'd3, 16'd2, 16'h0100);
            1:       set_cfg(16'h0002, 16'd0, 16'd2, 16'h0100);
            2:       set_cfg(rand_wf(), 16'd0, 16'd1, 16'h0011);
            default: set_cfg(w, 16'($urandom_range(1, 9)), 16'd1, 16'h0022);
         endcase
         do_start();
         $display("start rejected check: wf=%04h ton=%0d err=%b busy=%b", cfg_waveform, cfg_ton, cfg_err, busy);
         n_cmp++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL cfg_err_pulse: got err=%b busy=%b want 1/0", cfg_err, busy); end
         cyc();
         n_cmp++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL cfg_err_one_cycle: got err=%b busy=%b want 0/0", cfg_err, busy); end
      end
      // Invalid configuration presented for the re-latch at the end of TOFF.
      set_cfg(16'h0004, 16'd1, 16'd0, 16'h0033);
      do_start();
      run_pulse(1, -1, -1, 1'b1, 16'h0004, 16'd0, 16'd0, 16'h0044, dl, ol, ws, is, tb, db);
      exp_pulses++;
      n_cmp++; if (dl !== 4 || ol !== 1) begin n_bad++; $display("FAIL relatch_lengths: got dis=%0d off=%0d want 4/1", dl, ol); end
      n_cmp++; if (busy !== 1'b0 || cfg_err !== 1'b1) begin n_bad++; $display("FAIL relatch_err: got busy=%b err=%b want 0/1", busy, cfg_err); end
      cyc();
      n_cmp++; if (cfg_err !== 1'b0 || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL relatch_after: got err=%b pulses=%0d want 0/%0d", cfg_err, pulse_count, exp_pulses); end
   endtask

   task automatic test_short();
      int dl, ol, tb, db;
      logic [15:0] ws, is;
      set_cfg(16'h0002, 16'd3, 16'd2, 16'h0100);
      do_start();
      // Short on the third discharge cycle, then a short on the Ton-expiry
      // cycle (short must win) with a stop pending so the run ends in IDLE.
      run_pulse(2, -1, 2, 1'b0, 0, 0, 0, 0, dl, ol, ws, is, tb, db);
      exp_shorts++;
      n_cmp++; if (dl !== 3) begin n_bad++; $display("FAIL short_discharge_len: got %0d want 3", dl); end
      n_cmp++; if (ol !== SB * CPU + 8) begin n_bad++; $display("FAIL short_off_len: got %0d want %0d", ol, SB * CPU + 8); end
      n_cmp++; if (tb !== 0 || db !== 0) begin n_bad++; $display("FAIL short_timer_drive: got timer_errs=%0d drive_errs=%0d want 0", tb, db); end
      n_cmp++; if (short_count !== 16'(exp_shorts) || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL short_counts: got s=%0d p=%0d want %0d/%0d", short_count, pulse_count, exp_shorts, exp_pulses); end
      run_pulse(0, 11, 11, 1'b0, 0, 0, 0, 0, dl, ol, ws, is, tb, db);
      exp_shorts++;
      n_cmp++; if (dl !== 12 || ol !== SB * CPU + 8) begin n_bad++; $display("FAIL short_at_expiry_len: got dis=%0d off=%0d want 12/%0d", dl, ol, SB * CPU + 8); end
      n_cmp++; if (busy !== 1'b0 || short_count !== 16'(exp_shorts) || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL short_at_expiry_counts: got busy=%b s=%0d p=%0d want 0/%0d/%0d", busy, short_count, pulse_count, exp_shorts, exp_pulses); end
   endtask

   task automatic test_stop_mid();
      int dl, ol, tb, db;
      logic [15:0] ws, is;
      set_cfg(16'h8123, 16'd3, 16'd2, 16'h0100);
      do_start();
      run_pulse(1, 5, -1, 1'b0, 0, 0, 0, 0, dl, ol, ws, is, tb, db);
      exp_pulses++;
      n_cmp++; if (dl !== 12 || ol !== 8) begin n_bad++; $display("FAIL stop_mid_lengths: got dis=%0d off=%0d want 12/8", dl, ol); end
      n_cmp++; if (busy !== 1'b0 || open_voltage !== 1'b0 || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL stop_mid_end: got busy=%b open=%b p=%0d want 0/0/%0d", busy, open_voltage, pulse_count, exp_pulses); end
   endtask

   // Back-to-back pulses: configuration B is written during pulse A's
   // discharge and must only appear on the following pulse.
   task automatic test_back_to_back();
      int dl, ol, tb, db, sat, stat, last;
      logic [15:0] ws, is;
      logic [15:0] awf, aton, atoff, aip, bwf, bton, btoff, bip;
      for (int it = 0; it < 10; it++) begin
         awf = rand_wf(); aton = 16'($urandom_range(1, 4)); atoff = 16'($urandom_range(0, 3)); aip = 16'($urandom);
         bwf = rand_wf(); bton = 16'($urandom_range(1, 4)); btoff = 16'($urandom_range(0, 3)); bip = 16'($urandom);
         set_cfg(awf, aton, atoff, aip);
         do_start();
         run_pulse($urandom_range(0, 4), -1, -1, 1'b1, bwf, bton, btoff, bip, dl, ol, ws, is, tb, db);
         exp_pulses++;
         n_cmp++; if (dl !== int'(aton) * CPU || ol !== off_cycles(int'(atoff))) begin n_bad++; $display("FAIL b2b_a_lengths: got dis=%0d off=%0d want %0d/%0d", dl, ol, aton * CPU, off_cycles(int'(atoff))); end
         n_cmp++; if (ws !== awf || is !== aip || tb !== 0 || db !== 0) begin n_bad++; $display("FAIL b2b_a_drive: got wf=%h ip=%h terr=%0d derr=%0d want %h/%h/0/0", ws, is, tb, db, awf, aip); end
         n_cmp++; if (open_voltage !== 1'b1 || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL b2b_a_reopen: got open=%b p=%0d want 1/%0d", open_voltage, pulse_count, exp_pulses); end
         sat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(bton) * CPU - 1)) : -1;
         last = (sat >= 0) ? sat : int'(bton) * CPU - 1;
         stat = $urandom_range(0, last);
         run_pulse($urandom_range(0, 4), stat, sat, 1'b0, 0, 0, 0, 0, dl, ol, ws, is, tb, db);
         if (sat >= 0) exp_shorts++; else exp_pulses++;
         n_cmp++; if (dl !== ((sat >= 0) ? sat + 1 : int'(bton) * CPU)) begin n_bad++; $display("FAIL b2b_b_discharge_len: got %0d want %0d", dl, (sat >= 0) ? sat + 1 : int'(bton) * CPU); end
         n_cmp++; if (ol !== ((sat >= 0) ? SB * CPU : 0) + off_cycles(int'(btoff))) begin n_bad++; $display("FAIL b2b_b_off_len: got %0d want %0d", ol, ((sat >= 0) ? SB * CPU : 0) + off_cycles(int'(btoff))); end
         n_cmp++; if (ws !== bwf || is !== bip || tb !== 0 || db !== 0) begin n_bad++; $display("FAIL b2b_b_drive: got wf=%h ip=%h terr=%0d derr=%0d want %h/%h/0/0", ws, is, tb, db, bwf, bip); end
         n_cmp++; if (busy !== 1'b0 || pulse_count !== 32'(exp_pulses) || short_count !== 16'(exp_shorts)) begin n_bad++; $display("FAIL b2b_b_end: got busy=%b p=%0d s=%0d want 0/%0d/%0d", busy, pulse_count, short_count, exp_pulses, exp_shorts); end
      end
   endtask

   task automatic test_open_timeout();
      int len;
      set_cfg(16'h0002, 16'd2, 16'd1, 16'h0055);
      do_start();
      len = 0;
      while (open_voltage === 1'b1 && len < 1000) begin
         len++;
         cyc();
      end
`ifdef OPEN_TIMEOUT_EN
      $display("open timeout: open cycles=%0d", len);
      n_cmp++; if (len !== OMX * CPU) begin n_bad++; $display("FAIL open_timeout_len: got %0d want %0d", len, OMX * CPU); end
      len = 0;
      while (busy === 1'b1 && open_voltage === 1'b0 && len < 100) begin
         len++;
         cyc();
      end
      n_cmp++; if (len !== CPU || open_voltage !== 1'b1 || pulse_count !== 32'(exp_pulses)) begin n_bad++; $display("FAIL open_timeout_toff: got len=%0d open=%b p=%0d want %0d/1/%0d", len, open_voltage, pulse_count, CPU, exp_pulses); end
`else
      $display("open wait: open cycles=%0d", len);
      n_cmp++; if (len !== 1000 || open_voltage !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL open_no_timeout: got len=%0d open=%b busy=%b want 1000/1/1", len, open_voltage, busy); end
`endif
      stop = 1'b1; cyc(); stop = 1'b0;
      n_cmp++; if (busy !== 1'b0 || open_voltage !== 1'b0) begin n_bad++; $display("FAIL open_stop: got busy=%b open=%b want 0/0", busy, open_voltage); end
   endtask

   task automatic test_reset_mid();
      set_cfg(16'h0004, 16'd4, 16'd2, 16'h0777);
      do_start();
      cyc();
      breakdown = 1'b1; cyc(); breakdown = 1'b0;
      repeat (6) cyc();
      n_cmp++; if (ip_out !== 16'h0777 || pulse_count === 32'd0) begin n_bad++; $display("FAIL reset_mid_pre: got ip=%h p=%0d want 0777/nonzero", ip_out, pulse_count); end
      rst = 1'b1; cyc(); rst = 1'b0;
      $display("reset mid-discharge: open=%b wf=%h ip=%h timer=%0d p=%0d s=%0d busy=%b", open_voltage, waveform_out, ip_out, timer_us, pulse_count, short_count, busy);
      n_cmp++; if (open_voltage !== 1'b0 || waveform_out !== 16'd0 || ip_out !== 16'd0) begin n_bad++; $display("FAIL reset_mid_drive: got open=%b wf=%h ip=%h want 0", open_voltage, waveform_out, ip_out); end
      n_cmp++; if (timer_us !== 16'd0 || pulse_count !== 32'd0 || short_count !== 16'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_mid_state: got t=%0d p=%0d s=%0d busy=%b want 0", timer_us, pulse_count, short_count, busy); end
      cyc();
      n_cmp++; if (busy !== 1'b0 || open_voltage !== 1'b0) begin n_bad++; $display("FAIL reset_mid_idle: got busy=%b open=%b want 0/0", busy, open_voltage); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cfg_err();
      test_short();
      test_stop_mid();
      test_back_to_back();
      test_open_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
